// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 UART receiver (clk, reset, baudgen_tick, rxIN, rx_ack -> rxbyte, rx_valid, overrun, frame_err, busy)
module uart_rx_core (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudgen_tick,
  input  logic       rxIN,
  input  logic       rx_ack,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state, state_n;
  logic [3:0] s, s_n;
  logic [2:0] n, n_n;
  logic [7:0] b, b_n;
  logic rx_m, rx_s, stop_end, done, ferr;
  assign busy = state != IDLE;
  assign stop_end = state == STOP && baudgen_tick && s == 4'd15;
  assign done = stop_end && rx_s;
  assign ferr = stop_end && !rx_s;
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    b_n = b;
    if (state == IDLE) begin
      if (!rx_s) begin
        state_n = START;
        s_n = 4'd0;
      end
    end else if (baudgen_tick) begin
      s_n = s + 4'd1;
      if (state == START && s == 4'd7) begin
        state_n = rx_s ? IDLE : DATA;
        s_n = 4'd0;
        n_n = 3'd0;
      end else if (state == DATA && s == 4'd15) begin
        b_n = {rx_s, b[7:1]};
        n_n = n + 3'd1;
        state_n = n == 3'd7 ? STOP : DATA;
      end else if (stop_end) begin
        state_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {rx_s, rx_m} <= 2'b11;
      state <= IDLE;
      s <= 4'd0;
      n <= 3'd0;
      b <= 8'd0;
      rxbyte <= 8'd0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {rx_s, rx_m} <= {rx_m, rxIN};
      state <= state_n;
      s <= s_n;
      n <= n_n;
      b <= b_n;
      rxbyte <= done ? b : rxbyte;
      rx_valid <= done ? 1'b1 : rx_ack ? 1'b0 : rx_valid;
      overrun <= (done && rx_valid && !rx_ack) ? 1'b1 : rx_ack ? 1'b0 : overrun;
      frame_err <= ferr;
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core with directed frames
module tb_uart_rx_core;
  logic clk = 0, reset = 1, baudgen_tick = 0, rxIN = 1, rx_ack = 0;
  logic [7:0] rxbyte;
  logic rx_valid, overrun, frame_err, busy;
  logic [1:0] tcnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e, pb = 0;
  logic pv = 0, pfe = 0;
  bit auto_ack = 0;
  int fe_exp = 0, total = 0, bad = 0;

  uart_rx_core dut (
    .clk(clk), .reset(reset), .baudgen_tick(baudgen_tick), .rxIN(rxIN), .rx_ack(rx_ack),
    .rxbyte(rxbyte), .rx_valid(rx_valid), .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    baudgen_tick <= tcnt == 2'd3;
  end

  always @(negedge clk) rx_ack = auto_ack && rx_valid && !rx_ack;

  always @(negedge clk) begin
    if (!reset && rx_valid && (!pv || rxbyte != pb)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte got=%h expected=none", rxbyte);
      end else begin
        e = exp_q.pop_front();
        if (rxbyte !== e) begin
          bad++;
          $display("FAIL byte got=%h expected=%h", rxbyte, e);
        end
      end
    end
    if (frame_err) begin
      total++;
      if (fe_exp == 0 || pfe) begin
        bad++;
        $display("FAIL frame_err got=1 expected=0 (pending=%0d prev=%0b)", fe_exp, pfe);
      end else fe_exp--;
    end
    pv = rx_valid;
    pb = rxbyte;
    pfe = frame_err;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit good);
    if (good) exp_q.push_back(d);
    else fe_exp++;
    rxIN = 0;
    clks(64);
    for (int i = 0; i < 8; i++) begin
      rxIN = d[i];
      clks(64);
    end
    rxIN = good;
    clks(good ? 64 : 48);
    rxIN = 1;
    if (!good) clks(64);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rxbyte"}, rxbyte, 8'h00);
    check({tag, "_rx_valid"}, {7'd0, rx_valid}, 8'd0);
    check({tag, "_overrun"}, {7'd0, overrun}, 8'd0);
    check({tag, "_frame_err"}, {7'd0, frame_err}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    clks(4);
    check_reset_vals("reset");
    reset = 0;
    clks(10);
    send(8'h55, 1);
    check("b55_valid", {7'd0, rx_valid}, 8'd1);
    check("b55_rxbyte", rxbyte, 8'h55);
    check("b55_busy", {7'd0, busy}, 8'd0);
    #1 auto_ack = 1;
    clks(4);
    check("b55_ack_valid", {7'd0, rx_valid}, 8'd0);
    send(8'hA3, 1);
    send(8'h0F, 1);
    clks(10);
    check("b2b_overrun", {7'd0, overrun}, 8'd0);
    check("b2b_valid", {7'd0, rx_valid}, 8'd0);
    #1 auto_ack = 0;
    send(8'h11, 1);
    send(8'h22, 1);
    clks(10);
    check("ovr_rxbyte", rxbyte, 8'h22);
    check("ovr_valid", {7'd0, rx_valid}, 8'd1);
    check("ovr_overrun", {7'd0, overrun}, 8'd1);
    #1 auto_ack = 1;
    clks(3);
    check("ovr_ack_valid", {7'd0, rx_valid}, 8'd0);
    check("ovr_ack_overrun", {7'd0, overrun}, 8'd0);
    reset = 1;
    clks(3);
    reset = 0;
    clks(10);
    send(8'hC6, 0);
    check("ferr_valid", {7'd0, rx_valid}, 8'd0);
    check("ferr_rxbyte", rxbyte, 8'h00);
    check("ferr_busy", {7'd0, busy}, 8'd0);
    rxIN = 0;
    clks(8);
    check("glitch_busy_hi", {7'd0, busy}, 8'd1);
    clks(12);
    rxIN = 1;
    clks(40);
    check("glitch_busy_lo", {7'd0, busy}, 8'd0);
    check("glitch_valid", {7'd0, rx_valid}, 8'd0);
    #1 auto_ack = 0;
    send(8'h3C, 1);
    check("pre_abort_valid", {7'd0, rx_valid}, 8'd1);
    rxIN = 0;
    clks(64 * 5 + 32);
    check("abort_busy", {7'd0, busy}, 8'd1);
    reset = 1;
    rxIN = 1;
    clks(3);
    check_reset_vals("abort");
    reset = 0;
    clks(70);
    send(8'h7E, 1);
    clks(10);
    check("b7e_rxbyte", rxbyte, 8'h7E);
    check("b7e_valid", {7'd0, rx_valid}, 8'd1);
    check("b7e_overrun", {7'd0, overrun}, 8'd0);
    #1 auto_ack = 1;
    clks(5);
    check("pending_bytes", exp_q.size()[7:0], 8'd0);
    check("pending_ferr", fe_exp[7:0], 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
